// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      full,
    input  logic                      threshold,
    input  logic                      overflow,
    output logic                      wr_enb,
    output logic [DATA_W-1:0]         datain,
    output logic                      gnt_valid,
    output logic [ID_W-1:0]           gnt_id,
    output logic                      ovf_err
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [3:0]        beat_cnt;
    logic [4:0]        beat_next;
    logic [4:0]        limit;
    logic [ID_W-1:0]   sel_idx;
    logic [ID_W-1:0]   k_idx;
    logic              sel_found;
    logic              in_grant;
    logic              owner_valid;
    logic              beat;
    logic [DATA_W-1:0] req_words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign req_words[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        k_idx     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!sel_found && req_valid[k_idx]) begin
                sel_found = 1'b1;
                sel_idx   = k_idx;
            end
        end
    end

    assign in_grant    = (state == GRANT);
    assign owner_valid = req_valid[gnt_id];
    assign beat        = in_grant & owner_valid & ~full;
    assign beat_next   = {1'b0, beat_cnt} + 5'd1;
    // Threshold is re-sampled every cycle so a running burst is cut short.
    assign limit       = threshold ? 5'd1 : 5'(BURST_LEN);

    assign wr_enb = beat;
    assign datain = beat ? req_words[gnt_id] : '0;

    always_comb begin
        req_ready = '0;
        if (in_grant && !full) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            beat_cnt  <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            if (overflow) begin
                ovf_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sel_found && !full) begin
                        state     <= GRANT;
                        gnt_id    <= sel_idx;
                        rr_ptr    <= sel_idx;
                        beat_cnt  <= '0;
                        gnt_valid <= 1'b1;
                    end
                end
                GRANT: begin
                    // A dropped valid releases even when full is also high.
                    if (!owner_valid) begin
                        state     <= IDLE;
                        gnt_valid <= 1'b0;
                        beat_cnt  <= '0;
                    end else if (!full) begin
                        if (beat_next >= limit) begin
                            state     <= IDLE;
                            gnt_valid <= 1'b0;
                            beat_cnt  <= '0;
                        end else begin
                            beat_cnt <= beat_next[3:0];
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        full;
    logic        threshold;
    logic        overflow;
    logic        wr_enb;
    logic [7:0]  datain;
    logic        gnt_valid;
    logic [1:0]  gnt_id;
    logic        ovf_err;

    int tests_run    = 0;
    int tests_failed = 0;

    fifo_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .full     (full),
        .threshold(threshold),
        .overflow (overflow),
        .wr_enb   (wr_enb),
        .datain   (datain),
        .gnt_valid(gnt_valid),
        .gnt_id   (gnt_id),
        .ovf_err  (ovf_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    task automatic apply_reset();
        resetn    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        full      = 1'b0;
        threshold = 1'b0;
        overflow  = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] got;
        resetn = 1'b0;
        repeat (3) begin
            @(negedge clock);
            req_valid = 4'($urandom);
            req_data  = $urandom;
            full      = 1'($urandom);
            threshold = 1'($urandom);
            overflow  = 1'b1;
            #1;
            got = {gnt_valid, wr_enb, datain, req_ready, ovf_err};
            tests_run++;
            if (got !== 15'h0) begin
                tests_failed++;
                $display("FAIL reset_outputs got=%h exp=%h", got, 15'h0);
            end
        end
        @(posedge clock);
        #1;
        resetn    = 1'b1;
        req_valid = 4'b0011;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        full      = 1'b0;
        threshold = 1'b0;
        overflow  = 1'b0;
        #2;
        tests_run++;
        if ({gnt_valid, wr_enb, ovf_err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_first_idle got=%b exp=%b", {gnt_valid, wr_enb, ovf_err}, 3'b000);
        end
        next_cycle();
        #2;
        tests_run++;
        if ({gnt_valid, gnt_id, wr_enb, datain, req_ready} !== {1'b1, 2'd0, 1'b1, 8'hA0, 4'b0001}) begin
            tests_failed++;
            $display("FAIL reset_first_grant got=%h exp=%h",
                     {gnt_valid, gnt_id, wr_enb, datain, req_ready},
                     {1'b1, 2'd0, 1'b1, 8'hA0, 4'b0001});
        end
    endtask

    task automatic test_single_stream();
        logic [7:0]  data_t [10] = '{8'h10, 8'h10, 8'h11, 8'h12, 8'h13,
                                     8'h14, 8'h14, 8'h15, 8'h00, 8'h00};
        logic        val_t  [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        logic [15:0] exp_t  [10] = '{
            {1'b0, 2'd0, 1'b0, 8'h00, 4'b0000},
            {1'b1, 2'd2, 1'b1, 8'h10, 4'b0100},
            {1'b1, 2'd2, 1'b1, 8'h11, 4'b0100},
            {1'b1, 2'd2, 1'b1, 8'h12, 4'b0100},
            {1'b1, 2'd2, 1'b1, 8'h13, 4'b0100},
            {1'b0, 2'd2, 1'b0, 8'h00, 4'b0000},
            {1'b1, 2'd2, 1'b1, 8'h14, 4'b0100},
            {1'b1, 2'd2, 1'b1, 8'h15, 4'b0100},
            {1'b1, 2'd2, 1'b0, 8'h00, 4'b0100},
            {1'b0, 2'd2, 1'b0, 8'h00, 4'b0000}};
        logic [15:0] got;
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            req_valid = {1'b0, val_t[c], 2'b00};
            req_data  = {8'h00, data_t[c], 16'h0000};
            #2;
            got = {gnt_valid, gnt_id, wr_enb, datain, req_ready};
            tests_run++;
            if (got !== exp_t[c]) begin
                tests_failed++;
                $display("FAIL single_stream c=%0d got=%h exp=%h", c, got, exp_t[c]);
            end
        end
    endtask

    task automatic test_round_robin();
        int          order [5] = '{0, 1, 3, 0, 1};
        int          id;
        logic [15:0] exp;
        logic [15:0] got;
        apply_reset();
        for (int c = 0; c < 25; c++) begin
            next_cycle();
            req_valid = 4'b1011;
            req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
            #2;
            if (c % 5 == 0) begin
                id  = (c == 0) ? 0 : order[c / 5 - 1];
                exp = {1'b0, 2'(id), 1'b0, 8'h00, 4'b0000};
            end else begin
                id  = order[c / 5];
                exp = {1'b1, 2'(id), 1'b1, 8'hA0 + 8'(id), 4'b0001 << id};
            end
            got = {gnt_valid, gnt_id, wr_enb, datain, req_ready};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL round_robin c=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_full_stall();
        logic [7:0]  data_t [9] = '{8'hB0, 8'hB0, 8'hB1, 8'hB2, 8'hB2,
                                    8'hB2, 8'hB2, 8'hB3, 8'h00};
        logic        val_t  [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic        full_t [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        logic [15:0] exp_t  [9] = '{
            {1'b0, 2'd0, 1'b0, 8'h00, 4'b0000},
            {1'b1, 2'd1, 1'b1, 8'hB0, 4'b0010},
            {1'b1, 2'd1, 1'b1, 8'hB1, 4'b0010},
            {1'b1, 2'd1, 1'b0, 8'h00, 4'b0000},
            {1'b1, 2'd1, 1'b0, 8'h00, 4'b0000},
            {1'b1, 2'd1, 1'b0, 8'h00, 4'b0000},
            {1'b1, 2'd1, 1'b1, 8'hB2, 4'b0010},
            {1'b1, 2'd1, 1'b1, 8'hB3, 4'b0010},
            {1'b0, 2'd1, 1'b0, 8'h00, 4'b0000}};
        logic [15:0] got;
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            req_valid = {2'b00, val_t[c], 1'b0};
            req_data  = {16'h0000, data_t[c], 8'h00};
            full      = full_t[c];
            #2;
            got = {gnt_valid, gnt_id, wr_enb, datain, req_ready};
            tests_run++;
            if (got !== exp_t[c]) begin
                tests_failed++;
                $display("FAIL full_stall c=%0d got=%h exp=%h", c, got, exp_t[c]);
            end
        end
        full = 1'b0;
    endtask

    task automatic test_threshold();
        int          order [5] = '{0, 1, 2, 3, 0};
        int          id;
        logic [15:0] exp;
        logic [15:0] got;
        logic        thr_t [7] = '{0, 0, 0, 1, 1, 1, 1};
        logic [15:0] exp_t [7] = '{
            {1'b0, 2'd0, 1'b0, 8'h00, 4'b0000},
            {1'b1, 2'd2, 1'b1, 8'hE2, 4'b0100},
            {1'b1, 2'd2, 1'b1, 8'hE2, 4'b0100},
            {1'b1, 2'd2, 1'b1, 8'hE2, 4'b0100},
            {1'b0, 2'd2, 1'b0, 8'h00, 4'b0000},
            {1'b1, 2'd2, 1'b1, 8'hE2, 4'b0100},
            {1'b0, 2'd2, 1'b0, 8'h00, 4'b0000}};
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            req_valid = 4'b1111;
            req_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
            threshold = 1'b1;
            #2;
            if (c % 2 == 0) begin
                id  = (c == 0) ? 0 : order[c / 2 - 1];
                exp = {1'b0, 2'(id), 1'b0, 8'h00, 4'b0000};
            end else begin
                id  = order[c / 2];
                exp = {1'b1, 2'(id), 1'b1, 8'hC0 + 8'(id), 4'b0001 << id};
            end
            got = {gnt_valid, gnt_id, wr_enb, datain, req_ready};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL threshold_rr c=%0d got=%h exp=%h", c, got, exp);
            end
        end
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            req_valid = 4'b0100;
            req_data  = {8'h00, 8'hE2, 16'h0000};
            threshold = thr_t[c];
            #2;
            got = {gnt_valid, gnt_id, wr_enb, datain, req_ready};
            tests_run++;
            if (got !== exp_t[c]) begin
                tests_failed++;
                $display("FAIL threshold_cut c=%0d got=%h exp=%h", c, got, exp_t[c]);
            end
        end
        threshold = 1'b0;
    endtask

    task automatic test_overflow_and_reset();
        logic [15:0] got;
        logic [14:0] got_rst;
        apply_reset();
        next_cycle();
        req_valid = 4'b0010;
        req_data  = {16'h0000, 8'hD1, 8'h00};
        overflow  = 1'b1;
        #2;
        tests_run++;
        if (ovf_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_before got=%b exp=%b", ovf_err, 1'b0);
        end
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            overflow = 1'b0;
            #2;
            got = {gnt_valid, gnt_id, wr_enb, datain, req_ready};
            tests_run++;
            if (ovf_err !== 1'b1 || got !== {1'b1, 2'd1, 1'b1, 8'hD1, 4'b0010}) begin
                tests_failed++;
                $display("FAIL ovf_sticky_beat c=%0d got=%b/%h exp=%b/%h", c, ovf_err, got,
                         1'b1, {1'b1, 2'd1, 1'b1, 8'hD1, 4'b0010});
            end
        end
        #1 resetn = 1'b0;
        #1;
        got_rst = {gnt_valid, wr_enb, datain, req_ready, ovf_err};
        tests_run++;
        if (got_rst !== 15'h0) begin
            tests_failed++;
            $display("FAIL async_reset_midburst got=%h exp=%h", got_rst, 15'h0);
        end
        @(posedge clock);
        #1;
        resetn    = 1'b1;
        req_valid = 4'b1111;
        req_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        #2;
        tests_run++;
        if ({gnt_valid, wr_enb} !== 2'b00) begin
            tests_failed++;
            $display("FAIL post_reset_idle got=%b exp=%b", {gnt_valid, wr_enb}, 2'b00);
        end
        next_cycle();
        #2;
        got = {gnt_valid, gnt_id, wr_enb, datain, req_ready};
        tests_run++;
        if (got !== {1'b1, 2'd0, 1'b1, 8'hD0, 4'b0001}) begin
            tests_failed++;
            $display("FAIL post_reset_regrant got=%h exp=%h", got,
                     {1'b1, 2'd0, 1'b1, 8'hD0, 4'b0001});
        end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_round_robin();
        test_full_stall();
        test_threshold();
        test_overflow_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
